quarterwave_lut: RTL and testbench



---
 rtl/quarterwave_lut.sv | 69 ++++++
 tb/tb_quarterwave_lut.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/quarterwave_lut.sv
// Quarter-wave sine ROM for the NCO: quadrant-local phase index in, registered
// non-negative sine magnitude out, with the table built at elaboration from the parameters.
module quarterwave_lut #(
    parameter int DATA_WIDTH = 12,
    parameter int QLUT_DEPTH = 11
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic [QLUT_DEPTH-3:0]        address,
    output logic signed [DATA_WIDTH-1:0] value
);

    localparam int ADDR_W = QLUT_DEPTH - 2;
    localparam int N      = 1 << ADDR_W;
    localparam int AMP    = (1 << (DATA_WIDTH - 1)) - 1;

    generate
        if (QLUT_DEPTH < 3 || DATA_WIDTH < 2) begin : g_bad_params
            $error("quarterwave_lut: need QLUT_DEPTH >= 3 and DATA_WIDTH >= 2");
        end
    endgenerate

    // Sample k sits half a step into its bin, so entry(~k) is the cosine of
    // entry(k)'s angle and neither 0 nor pi/2 is ever stored. The Taylor series
    // keeps the table free of any dependence on tool math libraries.
    function automatic logic signed [DATA_WIDTH-1:0] qlut_entry(input int k);
        real x;
        real term;
        real s;
        x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(N);
        term = x;
        s    = x;
        for (int i = 1; i <= 12; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            s    = s + term;
        end
        // Argument is positive, so adding 0.5 and truncating rounds half away from 0.
        return DATA_WIDTH'($rtoi(real'(AMP) * s + 0.5));
    endfunction

    logic signed [DATA_WIDTH-1:0] rom [N];

    generate
        for (genvar k = 0; k < N; k++) begin : g_rom
            localparam logic signed [DATA_WIDTH-1:0] ENTRY = qlut_entry(k);
            assign rom[k] = ENTRY;
        end
    endgenerate

    logic signed [DATA_WIDTH-1:0] value_d;
    logic signed [DATA_WIDTH-1:0] value_q;

    // NOTE: the ROM is constant logic, not storage; only the output register is reset.
    always_comb begin
        value_d = rom[address];
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: tb/tb_quarterwave_lut.sv
// Self-checking bench for quarterwave_lut: default (512x12) and small (16x8)
// instances driven in lockstep, expected samples queued and popped one clk later.
module tb_quarterwave_lut;

    logic              clk;
    logic              arst;
    logic [8:0]        address;
    logic [3:0]        address_s;
    logic signed [11:0] value;
    logic signed [7:0]  value_s;

    quarterwave_lut u_dut (
        .clk     (clk),
        .arst    (arst),
        .address (address),
        .value   (value)
    );

    quarterwave_lut #(.DATA_WIDTH(8), .QLUT_DEPTH(6)) u_small (
        .clk     (clk),
        .arst    (arst),
        .address (address_s),
        .value   (value_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_s_q[$];
    int dut_vals[512];

    typedef struct {
        string name;
        int    addr;
        int    exp;
    } vec_t;

    function automatic int model(input int k, input int aw, input int dw);
        real n;
        real a;
        real x;
        n = real'(1 << aw);
        a = real'((1 << (dw - 1)) - 1);
        x = a * $sin(3.141592653589793 * (real'(k) + 0.5) / (2.0 * n));
        return $rtoi($floor(x + 0.5));
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one address on both instances (called at negedge), then compare
    // after the next rising edge against the queued expectations.
    task automatic step(input int a, output int got);
        address   = a[8:0];
        address_s = a[3:0];
        exp_q.push_back(model(a, 9, 12));
        exp_s_q.push_back(model(a % 16, 4, 8));
        @(posedge clk);
        @(negedge clk);
        got = int'(value);
        if (exp_q.size() == 0 || exp_s_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            check($sformatf("value[%0d]", a), got, exp_q.pop_front());
            check($sformatf("value_s[%0d]", a % 16), int'(value_s), exp_s_q.pop_front());
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   got;
        int   min_v;
        int   max_v;
        int   mono_bad;
        int   quad_bad;

        vecs[0] = '{"addr0",   0,   3};
        vecs[1] = '{"addr511", 511, 2047};
        vecs[2] = '{"addr255", 255, 1445};
        vecs[3] = '{"addr256", 256, 1450};
        vecs[4] = '{"addr1",   1,   model(1, 9, 12)};
        vecs[5] = '{"addr384", 384, model(384, 9, 12)};

        // Reset held with address toggling: output stays at zero.
        arst      = 1'b1;
        address   = '0;
        address_s = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            address   = 9'(i * 97 + 13);
            address_s = 4'(i * 5 + 3);
            @(posedge clk);
            #1;
            check("reset_hold", int'(value), 0);
            check("reset_hold_s", int'(value_s), 0);
        end
        @(negedge clk);
        arst = 1'b0;

        // Table-driven spot values (known-answer constants plus model points).
        for (int i = 0; i < 6; i++) begin
            address   = vecs[i].addr[8:0];
            address_s = '0;
            exp_s_q.push_back(model(0, 4, 8));
            @(posedge clk);
            @(negedge clk);
            check(vecs[i].name, int'(value), vecs[i].exp);
            check("spot_s", int'(value_s), exp_s_q.pop_front());
        end

        // Small instance boundary constants.
        address_s = 4'd0;
        @(posedge clk);
        @(negedge clk);
        check("small_entry0", int'(value_s), 6);
        address_s = 4'd15;
        @(posedge clk);
        @(negedge clk);
        check("small_entry15", int'(value_s), 127);

        // Full sweep, one address per clk.
        for (int k = 0; k < 512; k++) begin
            step(k, got);
            dut_vals[k] = got;
        end
        min_v = dut_vals[0];
        max_v = dut_vals[0];
        mono_bad = 0;
        quad_bad = 0;
        for (int k = 1; k < 512; k++) begin
            if (dut_vals[k] < dut_vals[k-1]) mono_bad++;
            if (dut_vals[k] < min_v) min_v = dut_vals[k];
            if (dut_vals[k] > max_v) max_v = dut_vals[k];
        end
        for (int k = 0; k < 512; k++) begin
            int sq;
            sq = dut_vals[k] * dut_vals[k] + dut_vals[511-k] * dut_vals[511-k];
            if (sq > 2047 * 2047 + 2 * 2047 || sq < 2047 * 2047 - 2 * 2047) quad_bad++;
        end
        check("sweep_min", min_v, 3);
        check("sweep_max", max_v, 2047);
        check("sweep_monotonic_violations", mono_bad, 0);
        check("quadrature_violations", quad_bad, 0);

        // Random order, back to back, with an asynchronous reset mid-stream.
        for (int i = 0; i < 200; i++) begin
            step(int'($urandom_range(0, 511)), got);
            if (i == 100) begin
                address = 9'd400;
                #2;
                arst = 1'b1;
                #1;
                check("async_reset", int'(value), 0);
                check("async_reset_s", int'(value_s), 0);
                exp_q.delete();
                exp_s_q.delete();
                repeat (2) begin
                    @(posedge clk);
                    #1;
                    check("reset_mid_hold", int'(value), 0);
                end
                @(negedge clk);
                arst = 1'b0;
                step(511, got);
                step(0, got);
            end
        end

        check("scoreboard_drained", exp_q.size() + exp_s_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
